// File: rtl/mem_sched_pkg.sv
// Shared state encodings, stall vectors and bus types for the memory-port scheduler.
package mem_sched_pkg;

  typedef enum logic [2:0] {
    SCHED_IDLE,
    SCHED_IF_BUSY,
    SCHED_LS_BUSY,
    SCHED_IF_DRAIN,
    SCHED_GAP
  } sched_state_e;

  typedef logic [5:0]  stall_bus_t;
  typedef logic [31:0] inst_bus_t;
  typedef logic [31:0] mem_addr_bus_t;

  localparam int BURST_W = 3;
  typedef logic [BURST_W-1:0] burst_cnt_t;

  localparam stall_bus_t STALL_LS = 6'b011111;
  localparam stall_bus_t STALL_IF = 6'b000011;

  function automatic burst_cnt_t burst_inc(burst_cnt_t cnt, burst_cnt_t max);
    return (cnt >= max) ? max : cnt + burst_cnt_t'(1);
  endfunction

endpackage

// File: rtl/mem_sched.sv
// Arbitrates the shared byte-serial memory port between instruction fetch and
// load/store, enforces the done-clear gap, drops stale fetches and drives stall.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int LS_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_pc_i,
  input  logic        ls_req_i,
  input  logic        flush_i,
  input  logic        if_mem_ctrl_done,
  input  logic        load_store_mem_ctrl_done,
  input  logic [31:0] if_rdata_i,
  output logic        if_request,
  output logic        load_store_request,
  output logic        if_cancel,
  output logic        if_inst_valid_o,
  output logic [31:0] if_inst_o,
  output logic        ls_ack_o,
  output logic [5:0]  stall,
  output logic [31:0] if_raddr
);

  localparam burst_cnt_t BURST_MAX = burst_cnt_t'(LS_BURST_MAX);

  sched_state_e state_q, state_d;
  burst_cnt_t   burst_q, burst_d;
  inst_bus_t    inst_q, inst_d;
  logic         if_request_q, if_request_d;
  logic         ls_request_q, ls_request_d;
  logic         cancel_q, cancel_d;
  logic         valid_q, valid_d;
  logic         ack_q, ack_d;
  stall_bus_t   stall_c;

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    inst_d   = inst_q;
    cancel_d = 1'b0;
    valid_d  = 1'b0;
    ack_d    = 1'b0;
    unique case (state_q)
      SCHED_IDLE: begin
        // LS has priority until it has starved a waiting fetch BURST_MAX times.
        if (ls_req_i && !(burst_q == BURST_MAX && if_req_i)) begin
          state_d = SCHED_LS_BUSY;
          burst_d = if_req_i ? burst_inc(burst_q, BURST_MAX) : '0;
        end else if (if_req_i) begin
          state_d = SCHED_IF_BUSY;
          burst_d = '0;
        end
      end
      SCHED_IF_BUSY: begin
        if (if_mem_ctrl_done) begin
          state_d = SCHED_GAP;
          if (!flush_i) begin
            valid_d = 1'b1;
            inst_d  = if_rdata_i;
          end
        end else if (flush_i) begin
          state_d  = SCHED_IF_DRAIN;
          cancel_d = 1'b1;
        end
      end
      SCHED_LS_BUSY: begin
        if (load_store_mem_ctrl_done) begin
          state_d = SCHED_GAP;
          ack_d   = 1'b1;
        end
      end
      // mem_ctrl finishes the byte sequence regardless, so keep requesting.
      SCHED_IF_DRAIN: begin
        if (if_mem_ctrl_done) state_d = SCHED_GAP;
      end
      SCHED_GAP: begin
        if (!if_mem_ctrl_done && !load_store_mem_ctrl_done) state_d = SCHED_IDLE;
      end
      default: state_d = SCHED_IDLE;
    endcase
    if_request_d = (state_d == SCHED_IF_BUSY) || (state_d == SCHED_IF_DRAIN);
    ls_request_d = (state_d == SCHED_LS_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SCHED_IDLE;
      burst_q      <= '0;
      inst_q       <= '0;
      if_request_q <= 1'b0;
      ls_request_q <= 1'b0;
      cancel_q     <= 1'b0;
      valid_q      <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      inst_q       <= inst_d;
      if_request_q <= if_request_d;
      ls_request_q <= ls_request_d;
      cancel_q     <= cancel_d;
      valid_q      <= valid_d;
      ack_q        <= ack_d;
    end
  end

  // A completion pulse releases the stall in the same cycle it is presented.
  always_comb begin
    stall_c = '0;
    if (ls_req_i && !ack_q)                      stall_c = STALL_LS;
    else if ((if_req_i || if_request_q) && !valid_q) stall_c = STALL_IF;
  end

  assign if_request         = if_request_q;
  assign load_store_request = ls_request_q;
  assign if_cancel          = cancel_q;
  assign if_inst_valid_o    = valid_q;
  assign if_inst_o          = inst_q;
  assign ls_ack_o           = ack_q;
  assign stall              = stall_c;
  assign if_raddr           = if_pc_i;

endmodule
